// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
// Module   : map_pkg
// Brief    : Shared widths and result record for the map stage and consumers.
// Revision : 1.0
// ============================================================================
package map_pkg;

    localparam int DP_W      = 9;
    localparam int DEF_SEQ_W = 4;

    typedef struct packed {
        logic [DEF_SEQ_W-1:0] seq;
        logic [DP_W-1:0]      dp;
    } map_result_t;

endpackage : map_pkg
`default_nettype wire

// File: rtl/map_fifo.sv
`default_nettype none
// ============================================================================
// Module   : map_fifo
// Brief    : Power-of-two FIFO with a registered head word and level count.
// Revision : 1.0
// ============================================================================
module map_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full     = (level_q == FULL_LVL);
        empty    = (level_q == '0);
        pop_ok   = pop & ~empty;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push_ok  = push & (~full | pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
        end
        // The next head is the word being written when it lands on the new read slot.
        if (level_d == '0) begin
            head_d = '0;
        end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            head_d = wdata;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            head_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign rdata = head_q;
    assign level = level_q;

endmodule : map_fifo
`default_nettype wire

// File: rtl/map_result_collect.sv
`default_nettype none
// ============================================================================
// Module   : map_result_collect
// Brief    : Captures map results on done rising, tags them and queues them.
// Revision : 1.0
// ============================================================================
module map_result_collect
    import map_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SEQ_W = DEF_SEQ_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             done,
    input  logic [DP_W-1:0]  dp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DP_W-1:0]  out_data,
    output logic [SEQ_W-1:0] out_seq,
    output logic [4:0]       level,
    output logic             overflow
);

    localparam int REC_W = SEQ_W + DP_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             done_q, done_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             overflow_q, overflow_d;
    logic             capture;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [REC_W-1:0] fifo_rdata;

    always_comb begin
        done_d     = done;
        capture    = done & ~done_q;
        pop        = out_valid & out_ready;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        if (capture) begin
            seq_d = seq_q + SEQ_W'(1);
        end
        // A drop only happens when no slot frees up in the same cycle.
        if (capture && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (clr) begin
            seq_d      = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q     <= 1'b0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= done_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    map_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .push  (capture),
        .pop   (pop),
        .wdata ({seq_q, dp}),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_rdata[DP_W-1:0];
    assign out_seq   = fifo_rdata[DP_W +: SEQ_W];
    assign level     = 5'(fifo_level);
    assign overflow  = overflow_q;

endmodule : map_result_collect
`default_nettype wire

// File: tb/tb_map_result_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_result_collect
// Brief    : Directed self-checking bench for map_result_collect (DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_map_result_collect;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clr;
    logic       done;
    logic [8:0] dp;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic [3:0] out_seq;
    logic [4:0] level;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int beats;

    map_result_collect #(
        .DEPTH (4),
        .SEQ_W (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clr       (clr),
        .done      (done),
        .dp        (dp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse(input logic [8:0] v);
        dp   = v;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    initial begin
        logic [8:0] exp_d [4];
        logic [3:0] exp_s [4];
        clr       = 1'b0;
        done      = 1'b1;
        dp        = 9'h0AA;
        out_ready = 1'b0;

        // Reset held with done high, then released mid-cycle.
        #1 reset = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_seq",   32'(out_seq),   32'd0);
        chk("rst_level", 32'(level),     32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        reset = 1'b1;
        tick();
        chk("rel_valid", 32'(out_valid), 32'd1);
        chk("rel_data",  32'(out_data),  32'h0AA);
        chk("rel_seq",   32'(out_seq),   32'd0);
        tick();
        chk("rel_once",  32'(level),     32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        done      = 1'b0;
        chk("rel_drain", 32'(level),     32'd0);

        // Single result with done held high and consumer always ready.
        clear_pulse();
        dp        = 9'h0DC;
        done      = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("one_data", 32'(out_data), 32'h0DC);
        chk("one_seq",  32'(out_seq),  32'd0);
        beats = out_valid ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (out_valid) beats++;
        end
        chk("one_beats", 32'(beats), 32'd1);
        chk("one_level", 32'(level), 32'd0);
        done      = 1'b0;
        out_ready = 1'b0;
        tick();

        // Fill past DEPTH, then drain.
        clear_pulse();
        for (int i = 1; i <= 5; i++) pulse(9'(i));
        chk("fill_level", 32'(level),    32'd4);
        chk("fill_ovf",   32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_data", 32'(out_data), 32'(k + 1));
            chk("drain_seq",  32'(out_seq),  32'(k));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_level", 32'(level),    32'd0);
        chk("ovf_sticky",  32'(overflow), 32'd1);
        dp   = 9'h006;
        done = 1'b1;
        tick();
        chk("post_ovf_seq", 32'(out_seq), 32'd5);
        done      = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovf_sticky2", 32'(overflow), 32'd1);

        // Full FIFO with capture and pop in the same cycle.
        clear_pulse();
        chk("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) pulse(9'(9'h010 + i));
        chk("full_level", 32'(level), 32'd4);
        dp        = 9'h1FF;
        done      = 1'b1;
        out_ready = 1'b1;
        tick();
        done = 1'b0;
        chk("fp_level", 32'(level),    32'd4);
        chk("fp_ovf",   32'(overflow), 32'd0);
        exp_d[0] = 9'h011; exp_d[1] = 9'h012; exp_d[2] = 9'h013; exp_d[3] = 9'h1FF;
        exp_s[0] = 4'd1;   exp_s[1] = 4'd2;   exp_s[2] = 4'd3;   exp_s[3] = 4'd4;
        for (int k = 0; k < 4; k++) begin
            chk("fp_data", 32'(out_data), 32'(exp_d[k]));
            chk("fp_seq",  32'(out_seq),  32'(exp_s[k]));
            tick();
        end
        out_ready = 1'b0;
        chk("fp_empty", 32'(out_valid), 32'd0);

        // Sequence tag wraps after 16 captures.
        clear_pulse();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            dp   = 9'(i);
            done = 1'b1;
            tick();
            chk("wrap_seq", 32'(out_seq), 32'(i % 16));
            done = 1'b0;
            tick();
            chk("wrap_level", 32'(level), 32'd0);
        end
        out_ready = 1'b0;

        // Clear wins over a simultaneous capture.
        clear_pulse();
        for (int i = 0; i < 3; i++) pulse(9'(9'h021 + i));
        chk("pre_clr_level", 32'(level), 32'd3);
        clr  = 1'b1;
        dp   = 9'h055;
        done = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_level", 32'(level),     32'd0);
        chk("clr_ovf2",  32'(overflow),  32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        tick();
        chk("clr_nowrite", 32'(level), 32'd0);
        done = 1'b0;
        tick();

        // Asynchronous reset in the middle of a cycle.
        pulse(9'h031);
        pulse(9'h032);
        chk("pre_rst_level", 32'(level), 32'd2);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_level", 32'(level),     32'd0);
        chk("arst_data",  32'(out_data),  32'd0);
        chk("arst_seq",   32'(out_seq),   32'd0);
        reset = 1'b1;
        tick();
        chk("arst_after", 32'(level), 32'd0);
        pulse(9'h077);
        chk("arst_seq0", 32'(out_seq),  32'd0);
        chk("arst_dat",  32'(out_data), 32'h077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_map_result_collect
`default_nettype wire
